int_sequencer: RTL and testbench
================================

# int_sequencer

Interrupt and return-from-interrupt sequencer for the five-stage pipelined processor. Latches the external `interrupt` pin, freezes and drains the pipeline, pushes the 32-bit resume PC and the 3-bit flags onto the stack through the shared 16-bit data-memory port, then redirects fetch to the ISR vector. On an RTI request it pops flags and PC in reverse order and restores them. Sits beside the fetch and memory stages, taking priority over the memory stage for the memory port while active.

## Interface
- `W`, 16, data-memory word width
- `PC_W`, 32, program-counter width
- `DRAIN_CYCLES`, 3, stall cycles to let in-flight instructions retire before stack traffic
- `VECTOR`, 32'h0000_0020, ISR entry address
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  synchronous, active-low reset
- `interrupt`  in  1  external interrupt, sampled each edge
- `pipe_ready`  in  1  pipeline at an interruptible point (no branch resolving, no multi-cycle op)
- `rti_req`  in  1  RTI decoded in memory stage, 1-cycle pulse
- `epc`  in  PC_W  resume address, sampled when leaving IDLE
- `flags_in`  in  3  current flags, sampled when leaving IDLE
- `mem_ack`  in  1  memory port completed current request this cycle
- `mem_rdata`  in  W  pop data, valid with `mem_ack`
- `stall`  out  1  freeze fetch/decode and hold PC
- `flush`  out  1  1-cycle pulse: kill IF/ID/EX contents
- `mem_req`  out  1  stack access request, held until `mem_ack`
- `mem_push`  out  1  1 = push (write M[SP], SP--), 0 = pop (SP++, read)
- `mem_wdata`  out  W  push data
- `pc_load`  out  1  1-cycle pulse: PC <= `pc_val`
- `pc_val`  out  PC_W  PC load value
- `flags_load`  out  1  1-cycle pulse: flags <= `flags_out`
- `flags_out`  out  3  restored flags
- `in_isr`  out  1  ISR active; further interrupts held pending

## Operation
- `pending` set on any cycle `interrupt`=1; cleared on IDLE->FLUSH. Pulses arriving while pending or while `in_isr`=1 merge into one pending request.
- IDLE: if `rti_req` & `in_isr` -> RSTALL. Else if `pending` & !`in_isr` & `pipe_ready` -> FLUSH, capturing `epc`/`flags_in`. RTI wins when both are eligible the same cycle.
- FLUSH: `flush`=1 one cycle, `stall`=1 -> DRAIN.
- DRAIN: counter `DRAIN_CYCLES`-1 down to 0, then -> PUSH_HI.
- PUSH_HI / PUSH_LO / PUSH_FL: `mem_req`=1, `mem_push`=1, `mem_wdata` = epc[31:16] / epc[15:0] / {13'b0, flags}. Advance on `mem_ack`.
- VEC: `pc_load`=1, `pc_val`=VECTOR, set `in_isr` -> IDLE.
- RSTALL: `stall`=1, `flush`=1 one cycle -> POP_FL.
- POP_FL / POP_LO / POP_HI: `mem_req`=1, `mem_push`=0. On `mem_ack`, capture `mem_rdata[2:0]` / lo / hi.
- RESTORE: `pc_load`=1, `pc_val`={hi,lo}, `flags_load`=1, clear `in_isr` -> IDLE.
- `stall`=1 in every state except IDLE.
- `rti_req` with `in_isr`=0 is ignored. `rti_req` outside IDLE is ignored.

## Timing
- Reset: state IDLE, `pending`=0, `in_isr`=0, all outputs 0, `pc_val`=0. Reset mid-sequence aborts immediately with no further memory request.
- Outputs are registered-state decodes, valid in the cycle the state is entered.
- Interrupt latency with zero-wait memory: edge sampling `interrupt` -> FLUSH next edge -> `pc_load` at 1+1+DRAIN_CYCLES+3 = 8 cycles after the sampling edge. Each memory wait cycle adds one.
- RTI latency with zero-wait memory: 1+3+1 = 5 cycles from `rti_req` to `pc_load`.
- `mem_req`, `mem_push`, `mem_wdata` are stable while awaiting `mem_ack`. `mem_ack` while `mem_req`=0 is ignored.

## Test plan
- Reset low 2 cycles, then high: all outputs 0, `in_isr`=0. Pulse `interrupt` during reset -> no `pending` afterwards.
- `epc`=32'h0001_2345, flags=3'b101, `pipe_ready`=1, `mem_ack` tied 1, `interrupt` 1-cycle pulse -> pushes 16'h0001, 16'h2345, 16'h0005 in order. `pc_load` with 32'h20 eight cycles after the sampling edge. `in_isr`=1.
- Same scenario with `mem_ack` delayed 2 cycles per access -> identical data and order. `pc_load` at cycle 14. Request signals held steady while waiting.
- In ISR: pulse `interrupt`, then `rti_req`; pops return 0005, 2345, 0001 -> `pc_val`=32'h0001_2345, `flags_out`=101. Pending interrupt then taken from IDLE.
- `interrupt` with `pipe_ready`=0 for 5 cycles -> stays IDLE with `stall`=0. Enters FLUSH on the first cycle `pipe_ready`=1.
- `rti_req` with `in_isr`=0 -> no state change. Reset asserted in PUSH_LO -> `mem_req` drops at the next edge.

Source files
------------

// File: rtl/int_sequencer.sv
// Interrupt entry/exit sequencer: drains the pipe, pushes PC and flags through the
// shared data-memory port, vectors to the ISR; RTI pops them back in reverse order.
module int_sequencer #(
   parameter int              W            = 16,
   parameter int              PC_W         = 32,
   parameter int              DRAIN_CYCLES = 3,
   parameter logic [PC_W-1:0] VECTOR       = 32'h0000_0020
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            interrupt,
   input  logic            pipe_ready,
   input  logic            rti_req,
   input  logic [PC_W-1:0] epc,
   input  logic [2:0]      flags_in,
   input  logic            mem_ack,
   input  logic [W-1:0]    mem_rdata,
   output logic            stall,
   output logic            flush,
   output logic            mem_req,
   output logic            mem_push,
   output logic [W-1:0]    mem_wdata,
   output logic            pc_load,
   output logic [PC_W-1:0] pc_val,
   output logic            flags_load,
   output logic [2:0]      flags_out,
   output logic            in_isr
);

   localparam int            CW       = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [CW-1:0] DRAIN_LD = CW'(DRAIN_CYCLES - 1);

   typedef enum logic [3:0] {
      IDLE, FLUSH, DRAIN, PUSH_HI, PUSH_LO, PUSH_FL, VEC,
      RSTALL, POP_FL, POP_LO, POP_HI, RESTORE
   } state_t;

   state_t          state, nxt;
   logic            pending;
   logic [CW-1:0]   cnt;
   logic [PC_W-1:0] epc_r;
   logic [2:0]      flags_r;
   logic [2:0]      pop_fl;
   logic [W-1:0]    pop_lo;
   logic            take;

   always_comb begin
      nxt = state;
      case (state)
         IDLE: begin
            // RTI has priority over a simultaneously eligible interrupt
            if (rti_req && in_isr)                      nxt = RSTALL;
            else if (pending && !in_isr && pipe_ready)  nxt = FLUSH;
         end
         FLUSH:   nxt = DRAIN;
         DRAIN:   if (cnt == '0) nxt = PUSH_HI;
         PUSH_HI: if (mem_ack) nxt = PUSH_LO;
         PUSH_LO: if (mem_ack) nxt = PUSH_FL;
         PUSH_FL: if (mem_ack) nxt = VEC;
         VEC:     nxt = IDLE;
         RSTALL:  nxt = POP_FL;
         POP_FL:  if (mem_ack) nxt = POP_LO;
         POP_LO:  if (mem_ack) nxt = POP_HI;
         POP_HI:  if (mem_ack) nxt = RESTORE;
         RESTORE: nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   assign take = (state == IDLE) && (nxt == FLUSH);

   // Outputs are decoded from the next state so they are valid the cycle a state is entered
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         pending    <= 1'b0;
         cnt        <= '0;
         epc_r      <= '0;
         flags_r    <= '0;
         pop_fl     <= '0;
         pop_lo     <= '0;
         stall      <= 1'b0;
         flush      <= 1'b0;
         mem_req    <= 1'b0;
         mem_push   <= 1'b0;
         mem_wdata  <= '0;
         pc_load    <= 1'b0;
         pc_val     <= '0;
         flags_load <= 1'b0;
         flags_out  <= '0;
         in_isr     <= 1'b0;
      end else begin
         state   <= nxt;
         pending <= interrupt | (pending & ~take);
         if (take) begin
            epc_r   <= epc;
            flags_r <= flags_in;
         end
         if (nxt == DRAIN && state != DRAIN) cnt <= DRAIN_LD;
         else if (state == DRAIN && cnt != '0) cnt <= cnt - 1'b1;
         if (mem_ack && state == POP_FL) pop_fl <= mem_rdata[2:0];
         if (mem_ack && state == POP_LO) pop_lo <= mem_rdata;

         stall    <= (nxt != IDLE);
         flush    <= (nxt == FLUSH) || (nxt == RSTALL);
         mem_req  <= (nxt == PUSH_HI) || (nxt == PUSH_LO) || (nxt == PUSH_FL) ||
                     (nxt == POP_FL)  || (nxt == POP_LO)  || (nxt == POP_HI);
         mem_push <= (nxt == PUSH_HI) || (nxt == PUSH_LO) || (nxt == PUSH_FL);
         case (nxt)
            PUSH_HI: mem_wdata <= epc_r[PC_W-1:W];
            PUSH_LO: mem_wdata <= epc_r[W-1:0];
            PUSH_FL: mem_wdata <= {{(W-3){1'b0}}, flags_r};
            default: mem_wdata <= '0;
         endcase

         pc_load    <= (nxt == VEC) || (nxt == RESTORE);
         flags_load <= (nxt == RESTORE);
         case (nxt)
            VEC:     pc_val <= VECTOR;
            // high half arrives on the same ack that moves us into RESTORE
            RESTORE: pc_val <= PC_W'({mem_rdata, pop_lo});
            default: pc_val <= '0;
         endcase
         flags_out <= (nxt == RESTORE) ? pop_fl : 3'b000;

         if (nxt == VEC)          in_isr <= 1'b1;
         else if (nxt == RESTORE) in_isr <= 1'b0;
      end
   end

endmodule

// File: tb/tb_int_sequencer.sv
// Randomized scoreboard bench for int_sequencer: stimulus queues expected stack traffic
// and PC loads; a negedge monitor pops and compares them against what the DUT presents.
module tb_int_sequencer;

   logic        clk = 1'b0, rst = 1'b0;
   logic        interrupt = 1'b0, pipe_ready = 1'b1, rti_req = 1'b0, mem_ack = 1'b0;
   logic [31:0] epc = '0;
   logic [2:0]  flags_in = '0;
   logic [15:0] mem_rdata = '0;
   logic        stall, flush, mem_req, mem_push, pc_load, flags_load, in_isr;
   logic [15:0] mem_wdata;
   logic [31:0] pc_val;
   logic [2:0]  flags_out;

   always #5 clk = ~clk;

   int_sequencer dut (
      .clk(clk), .rst(rst), .interrupt(interrupt), .pipe_ready(pipe_ready),
      .rti_req(rti_req), .epc(epc), .flags_in(flags_in), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .stall(stall), .flush(flush), .mem_req(mem_req),
      .mem_push(mem_push), .mem_wdata(mem_wdata), .pc_load(pc_load), .pc_val(pc_val),
      .flags_load(flags_load), .flags_out(flags_out), .in_isr(in_isr)
   );

   // kind: 0 = push, 1 = pop, 2 = pc load
   typedef struct {
      int          kind;
      logic [15:0] d;
      logic [31:0] pc;
      logic        fl;
      logic [2:0]  f;
   } ev_t;

   ev_t         exp_q[$];
   logic [15:0] stk[$];
   logic [31:0] ctx_pc = '0;
   logic [2:0]  ctx_f = '0;
   int          checks = 0, errors = 0, cyc = 0, pcl_cyc = 0, push_seen = 0;
   int          fixed_dly = 0;
   bit          rand_dly = 1'b0;
   int          rcnt = 0;
   bit          rbusy = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add_ev(input int k, input logic [15:0] d, input logic [31:0] pc,
                         input logic fl, input logic [2:0] f);
      ev_t e;
      e.kind = k; e.d = d; e.pc = pc; e.fl = fl; e.f = f;
      exp_q.push_back(e);
   endtask

   // Interrupt taken: context goes on the stack high-first, then fetch jumps to the vector
   task automatic expect_isr();
      add_ev(0, epc[31:16], '0, 1'b0, '0);
      add_ev(0, epc[15:0], '0, 1'b0, '0);
      add_ev(0, {13'b0, flags_in}, '0, 1'b0, '0);
      add_ev(2, '0, 32'h0000_0020, 1'b0, '0);
      ctx_pc = epc;
      ctx_f  = flags_in;
   endtask

   task automatic expect_rti();
      repeat (3) add_ev(1, '0, '0, 1'b0, '0);
      add_ev(2, '0, ctx_pc, 1'b1, ctx_f);
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_int(output int samp);
      @(negedge clk);
      interrupt = 1'b1;
      samp = cyc + 1;
      @(negedge clk);
      interrupt = 1'b0;
   endtask

   task automatic pulse_rti();
      @(negedge clk);
      rti_req = 1'b1;
      @(negedge clk);
      rti_req = 1'b0;
   endtask

   task automatic wait_isr(input logic want, input string name);
      int n = 0;
      while (in_isr !== want && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (in_isr !== want) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: in_isr %b expected %b", name, in_isr, want);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Memory model: a word stack with configurable wait states per access
   initial forever begin
      @(posedge clk);
      #1;
      if (!rst || !mem_req) begin
         rbusy   = 1'b0;
         mem_ack = 1'b0;
      end else begin
         if (mem_ack) begin
            mem_ack = 1'b0;
            rbusy   = 1'b0;
         end
         if (!rbusy) begin
            rbusy = 1'b1;
            rcnt  = rand_dly ? int'($urandom_range(0, 3)) : fixed_dly;
         end else begin
            rcnt--;
         end
         if (rcnt == 0) begin
            mem_ack = 1'b1;
            if (mem_push) stk.push_back(mem_wdata);
            else if (stk.size() > 0) mem_rdata = stk.pop_back();
            else mem_rdata = 16'h0;
         end
      end
   end

   initial begin : monitor
      bit          pw;
      logic        pp;
      logic [15:0] pd;
      ev_t         e;
      pw = 1'b0; pp = 1'b0; pd = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            pw = 1'b0;
         end else begin
            if (pw) begin
               chk("req_hold", mem_req, 1);
               chk("push_hold", mem_push, pp);
               chk("wdata_hold", mem_wdata, pd);
            end
            if (mem_req && mem_ack) begin
               if (exp_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_mem: push=%b wdata=%h with nothing expected", mem_push, mem_wdata);
               end else begin
                  e = exp_q.pop_front();
                  chk("mem_kind", mem_push ? 0 : 1, e.kind);
                  if (e.kind == 0 && mem_push) chk("push_data", mem_wdata, e.d);
                  if (mem_push) push_seen++;
               end
            end
            if (pc_load) begin
               if (exp_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_pc_load: pc_val=%h with nothing expected", pc_val);
               end else begin
                  e = exp_q.pop_front();
                  chk("ev_kind", 2, e.kind);
                  if (e.kind == 2) begin
                     chk("pc_val", pc_val, e.pc);
                     chk("flags_load", flags_load, e.fl);
                     if (e.fl) chk("flags_out", flags_out, e.f);
                  end
               end
               pcl_cyc = cyc;
            end
            pw = mem_req && !mem_ack;
            pp = mem_push;
            pd = mem_wdata;
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      int samp, n, base;
      samp = 0;
      // reset, with an interrupt pulse that must be forgotten
      @(negedge clk); interrupt = 1'b1;
      @(negedge clk); interrupt = 1'b0; rst = 1'b1;
      tick();
      chk("rst_stall", stall, 0);       chk("rst_flush", flush, 0);
      chk("rst_mem_req", mem_req, 0);   chk("rst_mem_push", mem_push, 0);
      chk("rst_wdata", mem_wdata, 0);   chk("rst_pc_load", pc_load, 0);
      chk("rst_pc_val", pc_val, 0);     chk("rst_flags_load", flags_load, 0);
      chk("rst_flags_out", flags_out, 0); chk("rst_in_isr", in_isr, 0);
      repeat (4) begin tick(); chk("no_pending_after_rst", stall, 0); end

      // zero-wait entry
      epc = 32'h0001_2345; flags_in = 3'b101; fixed_dly = 0;
      expect_isr(); pulse_int(samp); wait_isr(1, "isr0"); tick();
      chk("int_latency", pcl_cyc - samp, 8);
      chk("in_isr_set", in_isr, 1);

      // interrupt held pending in ISR, RTI, then pending one taken
      pulse_int(samp);
      expect_rti(); expect_isr();
      pulse_rti(); wait_isr(0, "rti0"); wait_isr(1, "isr1"); tick();
      expect_rti(); pulse_rti(); wait_isr(0, "rti1");

      // two wait states per access
      tick(2); fixed_dly = 2;
      expect_isr(); pulse_int(samp); wait_isr(1, "isr2"); tick();
      chk("int_latency_wait", pcl_cyc - samp, 14);
      expect_rti(); pulse_rti(); wait_isr(0, "rti2");
      fixed_dly = 0;

      // pipeline not interruptible
      tick(2); pipe_ready = 1'b0;
      expect_isr(); pulse_int(samp);
      chk("not_ready_stall", stall, 0);
      repeat (4) begin tick(); chk("not_ready_stall", stall, 0); end
      pipe_ready = 1'b1; tick();
      chk("flush_on_ready", flush, 1);
      wait_isr(1, "isr3"); tick();
      expect_rti(); pulse_rti(); wait_isr(0, "rti3");

      // RTI outside an ISR
      tick(2); pulse_rti();
      chk("rti_ignored_stall", stall, 0);
      tick();
      chk("rti_ignored_stall", stall, 0);
      chk("rti_ignored_isr", in_isr, 0);

      // randomized context, wait states, readiness and nesting
      rand_dly = 1'b1;
      for (int it = 0; it < 20; it++) begin
         bit nest;
         epc        = $urandom;
         flags_in   = 3'($urandom_range(0, 7));
         nest       = 1'($urandom_range(0, 1));
         pipe_ready = 1'($urandom_range(0, 1));
         expect_isr(); pulse_int(samp);
         tick(int'($urandom_range(0, 3)));
         pipe_ready = 1'b1;
         wait_isr(1, "isr_rnd"); tick();
         if (nest) pulse_int(samp);
         expect_rti();
         if (nest) expect_isr();
         pulse_rti(); wait_isr(0, "rti_rnd");
         if (nest) begin
            wait_isr(1, "isr_nest"); tick();
            expect_rti(); pulse_rti(); wait_isr(0, "rti_nest");
         end
         tick(int'($urandom_range(1, 4)));
      end
      rand_dly = 1'b0;

      // reset while the low PC half is being pushed
      fixed_dly = 4; base = push_seen; n = 0;
      epc = 32'hCAFE_0042; flags_in = 3'b011;
      expect_isr(); pulse_int(samp);
      while (!(push_seen == base + 1 && mem_req && !mem_ack) && n < 100) begin tick(); n++; end
      if (n >= 100) begin
         checks++; errors++;
         $display("FAIL push_lo_timeout: pushes seen %0d expected %0d", push_seen - base, 1);
      end
      rst = 1'b0; tick();
      chk("rst_mid_mem_req", mem_req, 0);
      chk("rst_mid_stall", stall, 0);
      chk("rst_mid_in_isr", in_isr, 0);
      rst = 1'b1; exp_q.delete(); stk.delete(); fixed_dly = 0;
      tick(3);
      chk("no_resume_after_rst", stall, 0);

      tick(2);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
